// File: rtl/qtr_scan_sched.sv
// qtr_scan_sched: sequences enabled QTR channels one at a time on each scan
// period, latches per-channel results/timeouts and raises end-of-scan
// scan_done / intr / estop pulses.
module qtr_scan_sched #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DBUS_WIDTH     = 8,
  parameter int unsigned CLK_FREQUENCY  = 60_000_000,
  parameter int unsigned TICK_CYCLES    = CLK_FREQUENCY / 20,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQUENCY / 250
) (
  input  logic                         hba_clk,
  input  logic                         hba_reset_n,
  input  logic [NUM_CH-1:0]            cfg_en_mask,
  input  logic [7:0]                   cfg_period,
  input  logic [DBUS_WIDTH-1:0]        cfg_thresh,
  input  logic                         cfg_intr_en,
  input  logic                         cfg_intr_type,
  input  logic                         cfg_estop_en,
  output logic [NUM_CH-1:0]            ch_start,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DBUS_WIDTH-1:0] ch_value,
  output logic [NUM_CH*DBUS_WIDTH-1:0] res_value,
  output logic                         res_wr,
  output logic [NUM_CH-1:0]            res_over,
  output logic [NUM_CH-1:0]            res_timeout,
  output logic                         busy,
  output logic                         scan_done,
  output logic                         intr,
  output logic                         estop,
  output logic                         sync_overrun
);

  localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [TICK_W-1:0]              tick_q, tick_d;
  logic [7:0]                     per_q, per_d;
  logic [TO_W-1:0]                to_q, to_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [NUM_CH-1:0]              scan_mask_q, scan_mask_d;
  logic [NUM_CH-1:0]              prev_over_q, prev_over_d;
  logic [NUM_CH-1:0]              ch_start_q, ch_start_d;
  logic [NUM_CH*DBUS_WIDTH-1:0]   res_value_q, res_value_d;
  logic [NUM_CH-1:0]              res_over_q, res_over_d;
  logic [NUM_CH-1:0]              res_timeout_q, res_timeout_d;
  logic                           res_wr_q, res_wr_d;
  logic                           busy_q, busy_d;
  logic                           scan_done_q, scan_done_d;
  logic                           intr_q, intr_d;
  logic                           estop_q, estop_d;
  logic                           overrun_q, overrun_d;

  logic                           trigger;
  logic [SEL_W-1:0]               first_sel, next_sel;
  logic                           first_found, next_found;
  logic [NUM_CH-1:0]              sel_oh;
  logic                           cur_valid;
  logic [DBUS_WIDTH-1:0]          cur_value;
  logic                           store_en, store_over, store_to;
  logic [DBUS_WIDTH-1:0]          store_val;

  // Base tick and scan-period trigger generation
  always_comb begin
    tick_d  = tick_q + 1'b1;
    per_d   = per_q;
    trigger = 1'b0;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (per_q == cfg_period) begin
        trigger = 1'b1;
        per_d   = '0;
      end else begin
        per_d = per_q + 1'b1;
      end
    end
  end

  // Channel selection: lowest enabled, next higher in scan, current channel mux
  always_comb begin
    first_sel   = '0;
    first_found = 1'b0;
    next_sel    = '0;
    next_found  = 1'b0;
    sel_oh      = '0;
    cur_valid   = 1'b0;
    cur_value   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!first_found && cfg_en_mask[i]) begin
        first_sel   = SEL_W'(i);
        first_found = 1'b1;
      end
      if (!next_found && scan_mask_q[i] && (SEL_W'(i) > sel_q)) begin
        next_sel   = SEL_W'(i);
        next_found = 1'b1;
      end
      if (SEL_W'(i) == sel_q) begin
        sel_oh[i] = 1'b1;
        cur_valid = ch_valid[i];
        cur_value = ch_value[i*DBUS_WIDTH +: DBUS_WIDTH];
      end
    end
  end

  // Scan FSM next-state, result update and output pulses
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    scan_mask_d   = scan_mask_q;
    to_d          = to_q;
    busy_d        = busy_q;
    prev_over_d   = prev_over_q;
    res_value_d   = res_value_q;
    res_over_d    = res_over_q;
    res_timeout_d = res_timeout_q;
    ch_start_d    = '0;
    res_wr_d      = 1'b0;
    scan_done_d   = 1'b0;
    intr_d        = 1'b0;
    estop_d       = 1'b0;
    overrun_d     = trigger && (state_q != S_IDLE);
    store_en      = 1'b0;
    store_val     = '0;
    store_over    = 1'b0;
    store_to      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger && (|cfg_en_mask)) begin
          scan_mask_d = cfg_en_mask;
          sel_d       = first_sel;
          busy_d      = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        ch_start_d = sel_oh;
        to_d       = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // valid is tested first so a reply coinciding with the timeout wins
        if (cur_valid) begin
          store_en   = 1'b1;
          store_val  = cur_value;
          store_over = (cur_value >= cfg_thresh);
          store_to   = 1'b0;
          res_wr_d   = 1'b1;
          state_d    = S_NEXT;
        end else if (to_q == TO_LAST) begin
          store_en   = 1'b1;
          store_val  = '1;
          store_over = 1'b1;
          store_to   = 1'b1;
          res_wr_d   = 1'b1;
          state_d    = S_NEXT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (next_found) begin
          sel_d   = next_sel;
          state_d = S_START;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        scan_done_d = 1'b1;
        busy_d      = 1'b0;
        intr_d      = cfg_intr_en & (cfg_intr_type ? (res_over_q != prev_over_q) : 1'b1);
        estop_d     = cfg_estop_en & (|(res_over_q & scan_mask_q));
        prev_over_d = res_over_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (store_en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (sel_oh[i]) begin
          res_value_d[i*DBUS_WIDTH +: DBUS_WIDTH] = store_val;
          res_over_d[i]    = store_over;
          res_timeout_d[i] = store_to;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q       <= S_IDLE;
      tick_q        <= '0;
      per_q         <= '0;
      to_q          <= '0;
      sel_q         <= '0;
      scan_mask_q   <= '0;
      prev_over_q   <= '0;
      ch_start_q    <= '0;
      res_value_q   <= '0;
      res_over_q    <= '0;
      res_timeout_q <= '0;
      res_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      scan_done_q   <= 1'b0;
      intr_q        <= 1'b0;
      estop_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      per_q         <= per_d;
      to_q          <= to_d;
      sel_q         <= sel_d;
      scan_mask_q   <= scan_mask_d;
      prev_over_q   <= prev_over_d;
      ch_start_q    <= ch_start_d;
      res_value_q   <= res_value_d;
      res_over_q    <= res_over_d;
      res_timeout_q <= res_timeout_d;
      res_wr_q      <= res_wr_d;
      busy_q        <= busy_d;
      scan_done_q   <= scan_done_d;
      intr_q        <= intr_d;
      estop_q       <= estop_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ch_start     = ch_start_q;
  assign res_value    = res_value_q;
  assign res_wr       = res_wr_q;
  assign res_over     = res_over_q;
  assign res_timeout  = res_timeout_q;
  assign busy         = busy_q;
  assign scan_done    = scan_done_q;
  assign intr         = intr_q;
  assign estop        = estop_q;
  assign sync_overrun = overrun_q;

endmodule

// File: tb/tb_qtr_scan_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for qtr_scan_sched: stimulus pushes expected starts,
// result writes and end-of-scan pulses; a monitor pops and compares.
module tb_qtr_scan_sched;

  localparam int NCH = 4;
  localparam int TMO = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       cfg_en_mask;
  logic [7:0]           cfg_period;
  logic [7:0]           cfg_thresh;
  logic                 cfg_intr_en;
  logic                 cfg_intr_type;
  logic                 cfg_estop_en;
  logic [NCH-1:0]       ch_start;
  logic [NCH-1:0]       ch_valid;
  logic [NCH*8-1:0]     ch_value;
  logic [NCH*8-1:0]     res_value;
  logic                 res_wr;
  logic [NCH-1:0]       res_over;
  logic [NCH-1:0]       res_timeout;
  logic                 busy;
  logic                 scan_done;
  logic                 intr;
  logic                 estop;
  logic                 sync_overrun;

  always #5 clk = ~clk;

  qtr_scan_sched #(
    .NUM_CH(NCH),
    .DBUS_WIDTH(8),
    .TICK_CYCLES(10),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .hba_clk(clk),
    .hba_reset_n(rst_n),
    .cfg_en_mask(cfg_en_mask),
    .cfg_period(cfg_period),
    .cfg_thresh(cfg_thresh),
    .cfg_intr_en(cfg_intr_en),
    .cfg_intr_type(cfg_intr_type),
    .cfg_estop_en(cfg_estop_en),
    .ch_start(ch_start),
    .ch_valid(ch_valid),
    .ch_value(ch_value),
    .res_value(res_value),
    .res_wr(res_wr),
    .res_over(res_over),
    .res_timeout(res_timeout),
    .busy(busy),
    .scan_done(scan_done),
    .intr(intr),
    .estop(estop),
    .sync_overrun(sync_overrun)
  );

  typedef struct packed {
    logic [31:0] val;
    logic [3:0]  over;
    logic [3:0]  tmo;
    logic [7:0]  lat;
  } wr_exp_t;

  typedef struct packed {
    logic       intr;
    logic       estop;
    logic [7:0] per;
  } done_exp_t;

  int        start_q[$];
  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int overrun_cnt = 0;

  // channel responder configuration
  int          dly[NCH];
  logic [7:0]  rval[NCH];
  logic [3:0]  reply_en = '0;
  logic [3:0]  spur_en  = '0;
  int          cnt[NCH];

  // bench-side model of the result registers
  logic [31:0] m_val  = '0;
  logic [3:0]  m_over = '0;
  logic [3:0]  m_to   = '0;
  logic [3:0]  m_prev = '0;

  // monitor state
  longint    cyc = 0;
  longint    start_cyc = 0;
  longint    wr_cyc = 0;
  longint    done_cyc = 0;
  int        e_idx;
  logic [3:0] e_oh;
  wr_exp_t   w;
  done_exp_t d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_ch(input int i, input logic [7:0] v, input int dl, input logic rep);
    rval[i] = v;
    dly[i]  = dl;
    reply_en[i] = rep;
    ch_value[i*8 +: 8] = v;
  endtask

  task automatic set_cfg(input logic [3:0] mask, input logic [7:0] per, input logic [7:0] th,
                         input logic ien, input logic ity, input logic een);
    cfg_en_mask   = mask;
    cfg_period    = per;
    cfg_thresh    = th;
    cfg_intr_en   = ien;
    cfg_intr_type = ity;
    cfg_estop_en  = een;
  endtask

  task automatic expect_scan(input logic [3:0] mask, input logic [7:0] th, input logic ien,
                             input logic ity, input logic een, input int per);
    wr_exp_t   we;
    done_exp_t de;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        start_q.push_back(i);
        if (reply_en[i]) begin
          m_val[i*8 +: 8] = rval[i];
          m_over[i] = (rval[i] >= th);
          m_to[i]   = 1'b0;
          we.lat    = 8'(dly[i] + 1);
        end else begin
          m_val[i*8 +: 8] = 8'hFF;
          m_over[i] = 1'b1;
          m_to[i]   = 1'b1;
          we.lat    = 8'(TMO);
        end
        we.val  = m_val;
        we.over = m_over;
        we.tmo  = m_to;
        wr_q.push_back(we);
      end
    end
    de.intr  = ien & ((ity == 1'b0) | (m_over != m_prev));
    de.estop = een & (|(m_over & mask));
    de.per   = 8'(per);
    m_prev   = m_over;
    done_q.push_back(de);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < budget);
    if (scan_done !== 1'b1) check("scan_done_wait", scan_done, 1);
  endtask

  // channel model: reply dly cycles after its start (spur channels react to any start)
  initial begin
    ch_valid = '0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      ch_valid = '0;
      for (int i = 0; i < NCH; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0 && reply_en[i]) ch_valid[i] = 1'b1;
        end
        if (ch_start[i] || (spur_en[i] && ch_start != '0)) cnt[i] = dly[i];
      end
    end
  end

  // monitor: sample just after each rising edge, pop and compare
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ch_start != '0) begin
        if (start_q.size() == 0) check("ch_start_unexpected", ch_start, 0);
        else begin
          e_idx = start_q.pop_front();
          e_oh  = 4'b0001 << e_idx;
          check("ch_start", ch_start, e_oh);
          start_cyc = cyc;
        end
      end
      if (res_wr) begin
        if (wr_q.size() == 0) check("res_wr_unexpected", res_wr, 0);
        else begin
          w = wr_q.pop_front();
          check("res_value", res_value, w.val);
          check("res_over", res_over, w.over);
          check("res_timeout", res_timeout, w.tmo);
          check("start_to_wr_latency", cyc - start_cyc, w.lat);
          check("busy_in_scan", busy, 1);
          wr_cyc = cyc;
        end
      end
      if (scan_done) begin
        if (done_q.size() == 0) check("scan_done_unexpected", scan_done, 0);
        else begin
          d = done_q.pop_front();
          check("intr", intr, d.intr);
          check("estop", estop, d.estop);
          check("wr_to_done_latency", cyc - wr_cyc, 2);
          if (d.per != 0) check("scan_period", cyc - done_cyc, d.per);
        end
        done_cyc = cyc;
      end else if (intr || estop) begin
        check("pulse_without_done", {intr, estop}, 0);
      end
      if (sync_overrun) overrun_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    ch_value = '0;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'h00, 0, 1'b0);
    set_cfg(4'b0101, 8'd2, 8'h80, 1'b1, 1'b1, 1'b1);
    set_ch(0, 8'h20, 5, 1'b1);
    set_ch(2, 8'h90, 5, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {ch_start, res_value, res_wr, res_over, res_timeout,
                            busy, scan_done, intr, estop, sync_overrun}, 0);

    // scans 1 and 2: channels 0 and 2, threshold change interrupt then none
    expect_scan(4'b0101, 8'h80, 1'b1, 1'b1, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(200);
    expect_scan(4'b0101, 8'h80, 1'b1, 1'b1, 1'b1, 30);
    wait_done(60);

    // scan 3: channel 1 silent -> timeout, then channel 2 below threshold
    set_ch(1, 8'h00, 0, 1'b0);
    set_ch(2, 8'h10, 3, 1'b1);
    set_cfg(4'b0110, 8'd2, 8'h80, 1'b1, 1'b0, 1'b0);
    expect_scan(4'b0110, 8'h80, 1'b1, 1'b0, 1'b0, 0);
    wait_done(60);

    // scan 4: valid on the timeout cycle wins; stray valids on channels 1 and 3
    set_ch(0, 8'h81, 15, 1'b1);
    set_ch(1, 8'hEE, 3, 1'b1);
    set_ch(3, 8'hEE, 5, 1'b1);
    spur_en = 4'b1010;
    set_cfg(4'b0001, 8'd2, 8'h80, 1'b0, 1'b0, 1'b1);
    expect_scan(4'b0001, 8'h80, 1'b0, 1'b0, 1'b1, 0);
    wait_done(60);
    spur_en = 4'b0000;
    check("no_overrun_yet", overrun_cnt, 0);

    // reset in the middle of a channel wait
    set_ch(0, 8'h33, 12, 1'b1);
    start_q.push_back(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_start[0] !== 1'b1 && n < 60);
    if (ch_start[0] !== 1'b1) check("ch_start_wait", ch_start[0], 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", {ch_start, res_value, res_wr, res_over, res_timeout,
                             busy, scan_done, intr, estop, sync_overrun}, 0);
    start_q.delete();
    wr_q.delete();
    done_q.delete();
    m_val  = '0;
    m_over = '0;
    m_to   = '0;
    m_prev = '0;
    repeat (10) @(negedge clk);

    // scan every tick with a reply longer than one tick -> one dropped trigger
    set_cfg(4'b1000, 8'd0, 8'h80, 1'b1, 1'b0, 1'b1);
    set_ch(3, 8'h7F, 14, 1'b1);
    overrun_cnt = 0;
    expect_scan(4'b1000, 8'h80, 1'b1, 1'b0, 1'b1, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, ch_start}, 0);
    wait_done(100);
    cfg_en_mask = '0;
    repeat (30) @(negedge clk);
    check("sync_overrun_count", overrun_cnt, 1);
    check("pending_expectations", start_q.size() + wr_q.size() + done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
